// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter; tick marks the last clk cycle of each line bit.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, one done_o pulse per byte.
// Defining UART_TX_PARITY_EN inserts an even-parity bit (8E1 framing).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       done_o,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  if (CLOCKS_PER_BAUD < 2) begin : g_cpb_check
    $error("uart_tx: CLOCKS_PER_BAUD must be at least 2");
  end

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      tx_q, tx_d;
  logic                      tick;
  logic                      accept;

  // Held in clear while idle so the first bit period starts at count 0.
  uart_baud_counter #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == IDLE),
    .tick (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      par_q <= ^data_i;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          shift_d = data_i;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so tx_o can be a flop.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    case (state_d)
      START:   tx_d = UART_START_LEVEL;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tx_q    <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == STOP) && tick;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLOCKS_PER_BAUD=4; follows UART_TX_PARITY_EN for framing.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;
  localparam int PERIOD    = FRAME_CYC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       start_i;
  logic       done_o;
  logic       busy_o;
  logic       tx_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic cap_tx   [0:511];
  logic cap_done [0:511];
  logic cap_busy [0:511];

  uart_tx #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .start_i(start_i),
    .done_o (done_o),
    .busy_o (busy_o),
    .tx_o   (tx_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected line level of bit b of a frame carrying byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic idle_watch(input string tag, input int cycles);
    int lows = 0;
    int dn   = 0;
    int bz   = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
      if (done_o !== 1'b0) dn++;
      if (busy_o !== 1'b0) bz++;
    end
    check({tag, " tx low cycles"}, lows, 0);
    check({tag, " done pulses"}, dn, 0);
    check({tag, " busy cycles"}, bz, 0);
  endtask

  // One frame; start_i held until cycle 'hold', data_i changed to chg_val at cycle 'chg'.
  task automatic send_frame(input string tag, input logic [7:0] d, input int hold,
                            input int chg, input logic [7:0] chg_val);
    int first_done = -1;
    int n_done     = 0;
    logic [CPB-1:0] bitv;
    @(negedge clk);
    data_i  = d;
    start_i = 1'b1;
    for (int k = 1; k <= FRAME_CYC + 2; k++) begin
      @(negedge clk);
      cap_tx[k]   = tx_o;
      cap_done[k] = done_o;
      cap_busy[k] = busy_o;
      if (k >= hold) start_i = 1'b0;
      if (k == chg) data_i = chg_val;
    end
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c < CPB; c++) bitv[c] = cap_tx[1 + b*CPB + c];
      check($sformatf("%s bit%0d", tag, b), bitv, {CPB{exp_bit(d, b)}});
    end
    for (int k = 1; k <= FRAME_CYC + 2; k++) begin
      if (cap_done[k] === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
    end
    check({tag, " done count"}, n_done, 1);
    check({tag, " done cycle"}, first_done, FRAME_CYC);
    check({tag, " busy first cycle"}, cap_busy[1], 1'b1);
    check({tag, " busy at done"}, cap_busy[FRAME_CYC], 1'b1);
    check({tag, " busy after done"}, cap_busy[FRAME_CYC+1], 1'b0);
  endtask

  task automatic back_to_back();
    logic [7:0] msg [0:6];
    logic [7:0] rx  [0:7];
    logic       stp [0:7];
    int dones [0:7];
    int nd     = 0;
    int n      = 0;
    int nf     = 0;
    int pos    = 1;
    int budget = 7*PERIOD + 60;
    logic upd  = 1'b0;
    msg[0] = 8'h4D; msg[1] = 8'h30; msg[2] = 8'h30; msg[3] = 8'h31;
    msg[4] = 8'h32; msg[5] = 8'h0D; msg[6] = 8'h0A;
    for (int i = 0; i < 8; i++) begin
      rx[i] = 8'h00; stp[i] = 1'b0; dones[i] = 0;
    end
    @(negedge clk);
    cap_tx[0] = tx_o;
    data_i    = msg[0];
    start_i   = 1'b1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      cap_tx[n] = tx_o;
      if (upd) begin
        data_i = msg[nd];
        upd    = 1'b0;
      end
      if (done_o === 1'b1) begin
        if (nd < 8) dones[nd] = n;
        nd++;
        if (nd < 7) upd = 1'b1;
        else start_i = 1'b0;
      end
    end
    // Receiver: find each falling edge, sample bits at mid-period.
    while (pos < n && nf < 8) begin
      if (cap_tx[pos] === 1'b0 && cap_tx[pos-1] === 1'b1) begin
        for (int bb = 0; bb < 8; bb++) rx[nf][bb] = cap_tx[pos + CPB/2 + CPB*(bb+1)];
        stp[nf] = cap_tx[pos + CPB/2 + CPB*(FRAME_BITS-1)];
        nf++;
        pos += CPB*FRAME_BITS - 1;
      end else begin
        pos++;
      end
    end
    check("b2b done count", nd, 7);
    check("b2b frames decoded", nf, 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("b2b byte%0d", i), rx[i], msg[i]);
      check($sformatf("b2b stop%0d", i), stp[i], 1'b1);
    end
    for (int i = 1; i < 7; i++) begin
      check($sformatf("b2b period%0d", i), (i < nd) ? dones[i] - dones[i-1] : -1, PERIOD);
    end
  endtask

  task automatic reset_mid_frame();
    @(negedge clk);
    data_i  = 8'h55;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (11) @(negedge clk);
    check("pre-rst busy", busy_o, 1'b1);
    check("pre-rst tx", tx_o, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst tx", tx_o, 1'b1);
    check("rst busy", busy_o, 1'b0);
    check("rst done", done_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_watch("post-rst", 60);
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    data_i  = 8'h00;
    #2;
    check("reset tx", tx_o, 1'b1);
    check("reset busy", busy_o, 1'b0);
    check("reset done", done_o, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    idle_watch("idle", 100);
    send_frame("f4D", 8'h4D, 0, -1, 8'h00);
    send_frame("f07", 8'h07, 0, -1, 8'h00);
    send_frame("mid", 8'h00, 14, 10, 8'hFF);
    idle_watch("mid-after", 20);
    back_to_back();
    idle_watch("b2b-after", 10);
    reset_mid_frame();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serialises one byte at a time onto the UART TX line: 8N1 framing, LSB first, fixed baud set by parameter.
- Sits directly downstream of the bridge transmit stage. Consumes its byte/start stream and returns a one-cycle done pulse per byte.
- Supports back-to-back frames with the start held high.

Parameters:
- CLOCKS_PER_BAUD, default 868: clk cycles per UART bit. Legal range is 2 or greater; elaboration-time error below 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_i  input  8  byte to send; sampled only on frame acceptance.
- start_i  input  1  request to send; level-sensitive, may be held high across frames.
- done_o  output  1  single-cycle pulse in the last clk cycle of the stop bit.
- busy_o  output  1  high from frame acceptance until the cycle after done_o.
- tx_o  output  1  serial line; idles high; registered output.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - tx_o=1, done_o=0, busy_o=0.
  - state=IDLE; baud counter and bit index cleared.
  - Reset mid-frame aborts the frame immediately; tx_o returns high with no partial stop bit.
- States and transitions:
  - IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- IDLE:
  - tx_o=1, busy_o=0.
  - If start_i=1 at a rising edge: latch data_i into an internal shift register, set busy_o=1, enter START.
  - tx_o drives 0 from that edge.
- Bit timing:
  - Every line bit (start, data, parity, stop) holds exactly CLOCKS_PER_BAUD cycles.
  - Baud counter runs 0..CLOCKS_PER_BAUD-1; width is clog2(CLOCKS_PER_BAUD).
  - The bit advances when the counter reaches CLOCKS_PER_BAUD-1; the counter wraps to 0.
- START: tx_o=0.
- DATA:
  - tx_o = shift register bit 0; shift right on each bit advance.
  - Bit index counts 0..7; leave DATA after index 7 completes.
- STOP:
  - tx_o=1.
  - done_o=1 only while the counter is CLOCKS_PER_BAUD-1 in STOP, so exactly one cycle per frame.
  - Next edge -> IDLE.
- Back-to-back:
  - The upstream stage updates data_i in the cycle after done_o.
  - The block sits in IDLE for exactly one cycle, then samples the new data_i/start_i.
  - The effective stop bit is therefore CLOCKS_PER_BAUD+1 cycles.
  - Frame period with start_i held high is 10*CLOCKS_PER_BAUD+1 cycles (11*CLOCKS_PER_BAUD+1 with parity).
- Latency: first falling edge of tx_o appears 1 cycle after start_i is sampled high in IDLE.
- Changes on start_i or data_i while busy_o=1 are ignored, including start_i dropping mid-frame; the frame always completes.
- start_i asserted in the same cycle as done_o is not accepted until the following IDLE cycle.
- Default case of the state register returns to IDLE with tx_o=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, lasting CLOCKS_PER_BAUD cycles.
  - tx_o = even parity, i.e. the XOR of the 8 latched data bits.
  - Parity is computed at acceptance from data_i and registered.
- Undefined:
  - No PARITY state, no parity register.
  - Frame is 8N1 exactly.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants IDLE/START/DATA/PARITY/STOP;
  - UART_DATA_BITS=8;
  - line-level constants UART_IDLE_LEVEL=1 and UART_START_LEVEL=0.
- One natural sub-module, uart_baud_counter:
  - parameter CLOCKS_PER_BAUD;
  - inputs clk, rst, clear;
  - output tick, high when count=CLOCKS_PER_BAUD-1.
  - uart_tx clears it on acceptance and advances bits on tick.

Test Plan:
- CLOCKS_PER_BAUD=4, start_i pulse with data_i=0x4D:
  - tx_o = 0, 1,0,1,1,0,0,1,0, 1, each bit held 4 cycles;
  - done_o high once, at cycle 40 after acceptance;
  - busy_o low the cycle after done_o.
- start_i held high with bytes 'M','0','0','1','2',CR,LF supplied by the upstream stage on each done_o:
  - seven frames decoded correctly by a bench UART receiver;
  - 41-cycle frame period;
  - exactly seven done_o pulses.
- data_i changed to 0xFF and start_i dropped mid-DATA of a 0x00 frame: line shows 0x00 fully; no second frame.
- rst asserted asynchronously mid-DATA (between edges): tx_o=1, busy_o=0, done_o=0 immediately; with start_i=0 after release, the line stays high.
- start_i=0 for 100 cycles after reset: tx_o constant 1, no done_o pulses.
- UART_TX_PARITY_EN, data_i=0x07:
  - parity bit 1; frame is 11 bits (44 cycles);
  - with data_i=0x4D, parity bit 0.
